// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among four byte-wide requesters.
// It launches one frame per grant, waits for done or timeout, then enforces an idle gap.
module uart_tx_arbiter #(
    parameter int unsigned gapClks     = 0,
    parameter logic [15:0] timeoutClks = 16'd60000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_req,
    input  logic [31:0] i_data,
    output logic [3:0]  o_grant,
    output logic [3:0]  o_done,
    output logic        o_timeout,
    output logic        o_busy,
    output logic        o_enableTx,
    output logic [7:0]  o_bitsTx,
    input  logic        i_doneTx
);

    localparam logic [15:0] TimeoutLast = timeoutClks - 16'd1;
    localparam logic [15:0] GapLast     = 16'(gapClks - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  bits_q, bits_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        enable_q, enable_d;
    logic        busy_q, busy_d;

    logic [1:0]  win_idx;
    logic [1:0]  cand;
    logic        win_valid;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        // Scan farthest-first so the nearest requester after last_q overwrites the rest.
        for (int i = 3; i >= 0; i--) begin
            cand = last_q + 2'(i + 1);
            if (i_req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        bits_d    = bits_q;
        grant_d   = 4'b0000;
        done_d    = 4'b0000;
        timeout_d = 1'b0;
        enable_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    bits_d           = i_data[{win_idx, 3'b000} +: 8];
                    grant_d[win_idx] = 1'b1;
                    last_d           = win_idx;
                    cnt_d            = 16'd0;
                    state_d          = StLaunch;
                end
            end
            StLaunch: begin
                enable_d = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 16'd1;
                if (i_doneTx || (cnt_q == TimeoutLast)) begin
                    // Done takes priority over a coincident timeout.
                    if (i_doneTx) begin
                        done_d[last_q] = 1'b1;
                    end else begin
                        timeout_d = 1'b1;
                    end
                    cnt_d   = 16'd0;
                    state_d = (gapClks == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = 16'd0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            last_q    <= 2'd3;
            cnt_q     <= 16'd0;
            bits_q    <= 8'h00;
            grant_q   <= 4'b0000;
            done_q    <= 4'b0000;
            timeout_q <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            bits_q    <= bits_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_done     = done_q;
    assign o_timeout  = timeout_q;
    assign o_busy     = busy_q;
    assign o_enableTx = enable_q;
    assign o_bitsTx   = bits_q;

endmodule
